// File: rtl/mdio_controller.sv
// MDIO management master for Clause 22 and Clause 45 frames.
// Takes one command on the cmd_* channel and issues one frame. It then returns exactly one
// response on the rsp_* channel and accepts nothing new until that response handshakes.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake; ready only in idle
//   cmd_clause45, cmd_op             frame type (ST) and OP field
//   cmd_phy_addr, cmd_reg_addr       PHYAD/PRTAD and REGAD/DEVAD fields
//   cmd_wdata                        write data or C45 register address
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               captured read data, turnaround error flag
//   busy                             command in flight (acceptance to response handshake)
//   mdc, mdio_i, mdio_o, mdio_t      management clock and tristate pad signals (t=1 releases)
module mdio_controller #(
    parameter int unsigned CLK_DIV       = 63,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clause45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int unsigned     DivW    = $clog2(2 * CLK_DIV);
    localparam logic [DivW-1:0] MdcRise = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] BitLast = DivW'(2 * CLK_DIV - 1);
    localparam logic [4:0]      PreLast = 5'((PREAMBLE_BITS == 0) ? 0 : PREAMBLE_BITS - 1);

    typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StTa, StData, StResp} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      bit_q, bit_d;
    // Non-preamble part of the frame; bit 31 is the bit currently on the wire.
    logic [31:0]     shift_q, shift_d;
    logic            read_q, read_d;
    logic            mdc_q, mdc_d;
    logic            mdio_o_q, mdio_o_d;
    logic            mdio_t_q, mdio_t_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     frame;
    logic            released;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        read_d      = read_q;
        mdc_d       = mdc_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        released    = 1'b0;
        frame = {(cmd_clause45 ? 2'b00 : 2'b01), cmd_op, cmd_phy_addr, cmd_reg_addr, 2'b10,
                 cmd_wdata};

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d  = (PREAMBLE_BITS == 0) ? StHeader : StPreamble;
                    shift_d  = frame;
                    read_d   = cmd_clause45 ? cmd_op[1] : (cmd_op == 2'b10);
                    div_d    = '0;
                    bit_d    = '0;
                    mdc_d    = 1'b0;
                    mdio_t_d = 1'b0;
                    mdio_o_d = (PREAMBLE_BITS == 0) ? frame[31] : 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                div_d = div_q + DivW'(1);
                // Sample on the clk edge that raises mdc.
                if (div_q == MdcRise) begin
                    mdc_d = 1'b1;
                    if (read_q && state_q == StTa && bit_q == 5'd1) err_d = mdio_i;
                    if (read_q && state_q == StData) rdata_d = {rdata_q[14:0], mdio_i};
                end
                // End of bit: mdc falls and the next bit goes out in the same cycle.
                if (div_q == BitLast) begin
                    div_d = '0;
                    mdc_d = 1'b0;
                    bit_d = bit_q + 5'd1;
                    case (state_q)
                        StPreamble: begin
                            if (bit_q == PreLast) begin
                                state_d = StHeader;
                                bit_d   = '0;
                            end
                        end
                        StHeader: begin
                            shift_d = shift_q << 1;
                            if (bit_q == 5'd13) begin
                                state_d = StTa;
                                bit_d   = '0;
                            end
                        end
                        StTa: begin
                            shift_d = shift_q << 1;
                            if (bit_q == 5'd1) begin
                                state_d = StData;
                                bit_d   = '0;
                            end
                        end
                        StData: begin
                            shift_d = shift_q << 1;
                            if (bit_q == 5'd15) begin
                                state_d     = StResp;
                                bit_d       = '0;
                                rsp_valid_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    released = read_q && (state_d inside {StTa, StData});
                    if (state_d == StResp) begin
                        mdio_o_d = 1'b1;
                        mdio_t_d = 1'b1;
                    end else if (state_d == StPreamble) begin
                        mdio_o_d = 1'b1;
                        mdio_t_d = 1'b0;
                    end else begin
                        mdio_t_d = released;
                        mdio_o_d = released ? 1'b1 : shift_d[31];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            read_q      <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            read_q      <= read_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = (state_q == StIdle) && !reset;
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Testbench for mdio_controller. Two instances share one clock.
// Instance 0 is built with a 32-bit preamble and instance 1 with no preamble.
// Both use CLK_DIV=2. Each frame's expected waveform and response are built from the frame
// fields.
module tb_mdio_controller;

    localparam int CD = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cmd_valid    [2];
    logic        cmd_ready    [2];
    logic        cmd_clause45 [2];
    logic [1:0]  cmd_op       [2];
    logic [4:0]  cmd_phy_addr [2];
    logic [4:0]  cmd_reg_addr [2];
    logic [15:0] cmd_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [15:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic        busy         [2];
    logic        mdc          [2];
    logic        mdio_i       [2];
    logic        mdio_o       [2];
    logic        mdio_t       [2];

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mdio_controller #(
            .CLK_DIV       (CD),
            .PREAMBLE_BITS ((g == 0) ? 32 : 0)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_clause45 (cmd_clause45[g]),
            .cmd_op       (cmd_op[g]),
            .cmd_phy_addr (cmd_phy_addr[g]),
            .cmd_reg_addr (cmd_reg_addr[g]),
            .cmd_wdata    (cmd_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .busy         (busy[g]),
            .mdc          (mdc[g]),
            .mdio_i       (mdio_i[g]),
            .mdio_o       (mdio_o[g]),
            .mdio_t       (mdio_t[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // phy_mode: 0 = PHY answers (TA bit 1 low), 1 = responder leaves TA bit 1 high,
    // 2 = nothing attached (line floats high).
    task automatic run_frame(input int u, input string name, input logic c45,
                             input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd, input int phy_mode,
                             input logic [15:0] pdata, input int stall);
        int          pre, n, c, k, ph, rsp_c, bad_ctl, bad_o, bad_t, bad_stall, first_bad;
        logic        rd, exp_err;
        logic [31:0] body;
        logic [63:0] exp_o, exp_t, drv, obs_o, mask;
        logic [15:0] exp_rdata;

        pre  = (u == 0) ? 32 : 0;
        n    = pre + 32;
        rd   = c45 ? op[1] : (op == 2'b10);
        body = {(c45 ? 2'b00 : 2'b01), op, phy, rg, 2'b10, wd};
        exp_o = '0; exp_t = '0; drv = '1; obs_o = '0; mask = '0;
        for (int i = 0; i < n; i++) begin
            exp_o[i] = (i < pre) ? 1'b1 : body[31 - (i - pre)];
            exp_t[i] = rd && (i >= pre + 14);
            mask[i]  = !exp_t[i];
            if (!rd) drv[i] = 1'($urandom);
            else if (phy_mode != 2) begin
                if (i == pre + 15) drv[i] = (phy_mode == 1);
                else if (i >= pre + 16) drv[i] = pdata[15 - (i - pre - 16)];
            end
        end
        exp_rdata = !rd ? 16'h0000 : ((phy_mode == 2) ? 16'hFFFF : pdata);
        exp_err   = rd && (phy_mode != 0);

        c = 0;
        while (cmd_ready[u] !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        vectors++;
        if (cmd_ready[u] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready[u]);
            return;
        end
        cmd_valid[u] = 1'b1; cmd_clause45[u] = c45; cmd_op[u] = op;
        cmd_phy_addr[u] = phy; cmd_reg_addr[u] = rg; cmd_wdata[u] = wd;
        tick();
        // Scramble the command fields: the frame must come from the latched copy.
        cmd_valid[u] = 1'b0; cmd_clause45[u] = 1'($urandom); cmd_op[u] = 2'($urandom);
        cmd_phy_addr[u] = 5'($urandom); cmd_reg_addr[u] = 5'($urandom);
        cmd_wdata[u] = 16'($urandom);

        rsp_c = -1; bad_ctl = 0; bad_o = 0; bad_t = 0; first_bad = -1;
        for (c = 1; c <= 2 * CD * n + 8; c++) begin
            if (c > 1) tick();
            if (rsp_valid[u] === 1'b1) begin
                rsp_c = c;
                break;
            end
            k  = (c - 1) / (2 * CD);
            ph = (c - 1) % (2 * CD);
            if (k < n) begin
                if (ph == 0) mdio_i[u] = drv[k];
                if (mdc[u] !== (ph >= CD) || busy[u] !== 1'b1 || cmd_ready[u] !== 1'b0) begin
                    bad_ctl++;
                    if (first_bad < 0) first_bad = c;
                end
                if (mdio_t[u] !== exp_t[k]) bad_t++;
                if (!exp_t[k] && mdio_o[u] !== exp_o[k]) bad_o++;
                if (ph == CD) obs_o[k] = mdio_o[u];
            end else begin
                bad_ctl++;
            end
        end

        vectors++;
        if (rsp_c != 1 + 2 * CD * n) begin
            miscompares++;
            $display("FAIL %s rsp_cycle: got %0d want %0d", name, rsp_c, 1 + 2 * CD * n);
        end
        vectors++;
        if (bad_ctl !== 0) begin
            miscompares++;
            $display("FAIL %s mdc/busy: %0d bad cycles (first %0d) want 0", name, bad_ctl,
                     first_bad);
        end
        vectors++;
        if (bad_t !== 0) begin
            miscompares++;
            $display("FAIL %s mdio_t: %0d bad cycles want 0", name, bad_t);
        end
        vectors++;
        if (bad_o !== 0) begin
            miscompares++;
            $display("FAIL %s mdio_o: %0d bad cycles want 0", name, bad_o);
        end
        vectors++;
        if ((obs_o & mask) !== (exp_o & mask)) begin
            miscompares++;
            $display("FAIL %s bits_at_rise: got %h want %h", name, obs_o & mask, exp_o & mask);
        end
        vectors++;
        if (rsp_rdata[u] !== exp_rdata || rsp_err[u] !== exp_err) begin
            miscompares++;
            $display("FAIL %s response: got rdata=%h err=%b want rdata=%h err=%b", name,
                     rsp_rdata[u], rsp_err[u], exp_rdata, exp_err);
        end
        vectors++;
        if ({mdc[u], mdio_t[u], mdio_o[u], busy[u]} !== 4'b0111) begin
            miscompares++;
            $display("FAIL %s pad_in_resp: got mdc,t,o,busy=%b want 0111", name,
                     {mdc[u], mdio_t[u], mdio_o[u], busy[u]});
        end

        bad_stall = 0;
        for (int s = 0; s < stall; s++) begin
            tick();
            cmd_valid[u] = (s == stall / 2);
            if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== exp_rdata || rsp_err[u] !== exp_err ||
                mdc[u] !== 1'b0 || cmd_ready[u] !== 1'b0 || busy[u] !== 1'b1 ||
                mdio_t[u] !== 1'b1)
                bad_stall++;
        end
        cmd_valid[u] = 1'b0;
        if (stall > 0) begin
            vectors++;
            if (bad_stall !== 0) begin
                miscompares++;
                $display("FAIL %s stall: %0d unstable cycles want 0", name, bad_stall);
            end
        end

        rsp_ready[u] = 1'b1;
        tick();
        rsp_ready[u] = 1'b0;
        vectors++;
        if ({rsp_valid[u], busy[u], cmd_ready[u], mdc[u]} !== 4'b0010) begin
            miscompares++;
            $display("FAIL %s after_handshake: got valid,busy,ready,mdc=%b want 0010", name,
                     {rsp_valid[u], busy[u], cmd_ready[u], mdc[u]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0; cmd_clause45[u] = 1'b0; cmd_op[u] = 2'b00;
            cmd_phy_addr[u] = '0; cmd_reg_addr[u] = '0; cmd_wdata[u] = '0;
            rsp_ready[u] = 1'b0; mdio_i[u] = 1'b1;
        end
        tick();
        tick();
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if ({mdc[u], mdio_o[u], mdio_t[u], cmd_ready[u], rsp_valid[u], rsp_err[u],
                 busy[u], rsp_rdata[u]} !== {7'b0110000, 16'h0000}) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %b/%h want 0110000/0000", u,
                         {mdc[u], mdio_o[u], mdio_t[u], cmd_ready[u], rsp_valid[u],
                          rsp_err[u], busy[u]}, rsp_rdata[u]);
            end
        end
        reset = 1'b0;
        tick();
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (cmd_ready[u] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: cmd_ready got %b want 1", u, cmd_ready[u]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        cmd_valid[0] = 1'b1; cmd_clause45[0] = 1'b0; cmd_op[0] = 2'b10;
        cmd_phy_addr[0] = 5'h0C; cmd_reg_addr[0] = 5'h02; cmd_wdata[0] = 16'h0;
        tick();
        cmd_valid[0] = 1'b0;
        mdio_i[0] = 1'b0;
        for (int c = 2; c <= 100; c++) tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({mdc[0], mdio_t[0], busy[0], rsp_valid[0], cmd_ready[0]} !== 5'b01000) begin
            miscompares++;
            $display("FAIL reset_mid_frame: got mdc,t,busy,valid,ready=%b want 01000",
                     {mdc[0], mdio_t[0], busy[0], rsp_valid[0], cmd_ready[0]});
        end
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || mdc[0] !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL dropped_read: %0d cycles with activity want 0", bad);
        end
        run_frame(0, "write_after_reset", 1'b0, 2'b01, 5'h1F, 5'h04, 16'hA5C3, 0, 16'h0, 0);
    endtask

    task automatic test_random();
        int u, mode, st;
        logic c45;
        logic [1:0] op;
        for (int i = 0; i < 12; i++) begin
            u    = int'($urandom_range(0, 1));
            c45  = 1'($urandom);
            op   = 2'($urandom);
            mode = int'($urandom_range(0, 2));
            st   = int'($urandom_range(0, 3));
            run_frame(u, "random", c45, op, 5'($urandom), 5'($urandom), 16'($urandom), mode,
                      16'($urandom), st);
        end
    endtask

    initial begin
        test_reset();
        run_frame(0, "c22_write", 1'b0, 2'b01, 5'h0C, 5'h00, 16'h1140, 0, 16'h0, 0);
        run_frame(0, "c22_read", 1'b0, 2'b10, 5'h0C, 5'h02, 16'h1234, 0, 16'h0141, 0);
        run_frame(0, "no_phy_read", 1'b0, 2'b10, 5'h05, 5'h01, 16'h0, 2, 16'h0, 0);
        run_frame(1, "c45_address", 1'b1, 2'b00, 5'h03, 5'h01, 16'h0800, 0, 16'h0, 0);
        run_frame(1, "c45_read", 1'b1, 2'b11, 5'h03, 5'h01, 16'h0, 0, 16'hBEEF, 0);
        run_frame(0, "backpressure", 1'b0, 2'b10, 5'h0C, 5'h03, 16'h0, 0, 16'h5A5A, 50);
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
